// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with an in-order response queue.
// Issues word-aligned fetches, tracks in-flight requests, buffers responses
// in a circular queue toward decode, and drops stale responses after a
// redirect by means of a discard counter.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (adds fetch_fault output;
// a misaligned redirect target halts fetch until an aligned redirect).
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     QUEUE_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          slot_q [QUEUE_DEPTH];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;   // PC of the next live response
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [CW-1:0]   outst_q,    outst_d;    // live requests awaiting response
  logic [CW-1:0]   discard_q,  discard_d;  // stale responses still to drop

  logic [SW-1:0]   inflight;
  logic [XLEN-1:0] redir_tgt;
  logic            halted;
  logic            req_fire;
  logic            rsp_stale;
  logic            push;
  logic            pop;

  // Redirect targets are always word aligned for the fetch path.
  assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign halted      = fault_q;
  assign fetch_fault = fault_q;

  // Fault tracks the alignment of the most recent redirect target.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = |redirect_pc[1:0];
  end

  // Fault flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`else
  logic unused_redir_lo;
  assign halted          = 1'b0;
  assign unused_redir_lo = ^redirect_pc[1:0];
`endif

  // Stale responses in flight still occupy memory slots, so they count
  // against the occupancy limit; this also bounds the discard counter.
  assign inflight = SW'(count_q) + SW'(outst_q) + SW'(discard_q);

  assign imem_req_valid = rst_n && !redirect_valid && !halted &&
                          (inflight < SW'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_stale = redirect_valid || (discard_q != '0);
  assign push      = imem_rsp_valid && !rsp_stale;
  assign inst_valid = (count_q != '0);
  assign pop       = inst_valid && inst_ready;

  assign inst_data = slot_q[rd_ptr_q].data;
  assign inst_pc   = slot_q[rd_ptr_q].pc;

  // Next-state for fetch PC, queue pointers and in-flight bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      // Everything in flight becomes stale; a response landing now is
      // already dropped, so it is not added to the discard count.
      fetch_pc_d = redir_tgt;
      rsp_pc_d   = redir_tgt;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      outst_d    = '0;
      discard_d  = discard_q + outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d   = count_q + CW'(push) - CW'(pop);
      outst_d   = outst_q + CW'(req_fire) - CW'(push);
      discard_d = discard_q - CW'(imem_rsp_valid && (discard_q != '0));
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // Queue storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr_q] <= '{pc: rsp_pc_q, data: imem_rsp_data};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a 1-cycle memory model
// (grant budget, stall and response-hold knobs) and an instruction scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .QUEUE_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          grant   = 0;
  logic        rsp_hold  = 1'b0;
  logic        mem_stall = 1'b0;
  pend_t       pend[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_F00F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: inputs change at negedge, sampled by the DUT at posedge.
  always @(negedge clk) begin
    pend_t ent;
    if (!rst_n) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
    end else begin
      if (!rsp_hold && pend.size() > 0 && pend[0].due <= cyc) begin
        ent = pend.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mdata(ent.addr);
      end else begin
        imem_rsp_valid = 1'b0;
      end
      imem_req_ready = !mem_stall && (grant > 0);
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{addr: imem_req_addr, due: cyc + 1});
        grant--;
      end
    end
  end

  // Scoreboard: every delivered instruction must match the next expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && inst_valid && inst_ready) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_extra: observed pc %h expected none", inst_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", inst_pc, e);
        check("sb_data", inst_data, mdata(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);

    // Streaming after reset release: one instruction per cycle from cycle 2.
    grant = 13; inst_ready = 1'b1;
    push_exp(32'h0, 12);
    rst_n = 1'b1;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    tick();
    check("fill_c1_valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("thru_valid", 32'(inst_valid), 32'd1);
    end

    // Decode stall: queue fills to depth, fetch throttles.
    tick();
    inst_ready = 1'b0;
    repeat (9) tick();
    tick();
    check("full_head_valid", 32'(inst_valid), 32'd1);
    check("full_head_pc", inst_pc, 32'h20);
    check("full_req_valid", 32'(imem_req_valid), 32'd0);

    // Drain exactly four while memory stalls; request held stable.
    mem_stall = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_req_valid", 32'(imem_req_valid), 32'd1);
      check("stall_req_addr", imem_req_addr, 32'h30);
    end
    tick();
    check("drain_empty", 32'(inst_valid), 32'd0);
    check("drain_sb_left", 32'(exp_q.size()), 32'd0);
    mem_stall = 1'b0;
    push_exp(32'h30, 1);
    repeat (4) tick();
    check("resume_sb_left", 32'(exp_q.size()), 32'd0);

    // Redirect with two requests in flight: both responses dropped.
    grant = 2; rsp_hold = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("redir_req_suppr", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; rsp_hold = 1'b0; grant = 4;
    push_exp(32'h100, 4);
    #1;
    check("redir_inst_valid", 32'(inst_valid), 32'd0);
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h100);
    repeat (12) tick();
    check("redir_sb_left", 32'(exp_q.size()), 32'd0);

    // Back-to-back redirects, one response landing in the first redirect cycle.
    grant = 3; rsp_hold = 1'b1;
    repeat (3) tick();
    rsp_hold = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    #1;
    check("b2b_inst_valid1", 32'(inst_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; grant = 2;
    push_exp(32'h300, 2);
    #1;
    check("b2b_inst_valid2", 32'(inst_valid), 32'd0);
    check("b2b_req_addr", imem_req_addr, 32'h300);
    repeat (10) tick();
    check("b2b_sb_left", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation: two queued, two in flight (occupancy limit).
    inst_ready = 1'b0; grant = 4;
    tick();
    tick();
    tick();
    rsp_hold = 1'b1;
    tick();
    tick();
    check("pre_rst_head_pc", inst_pc, 32'h308);
    check("pre_rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    rsp_hold = 1'b0; grant = 1; inst_ready = 1'b1;
    push_exp(32'h0, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rerst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rerst_req_addr", imem_req_addr, 32'h0);
    repeat (6) tick();
    check("rerst_sb_left", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect faults and halts; aligned redirect recovers.
    grant = 4;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("fault_set", 32'(fetch_fault), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fault_no_req", 32'(imem_req_valid), 32'd0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    push_exp(32'h200, 4);
    #1;
    check("fault_clear", 32'(fetch_fault), 32'd0);
    check("fault_req_addr", imem_req_addr, 32'h200);
    repeat (10) tick();
    check("fault_sb_left", 32'(exp_q.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
